// File: rtl/pec_tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM master port among NB_REQ requesters, with an
// in-order ID FIFO for response routing. Optional grant statistics: PEC_TCDM_ARB_STATS_EN.
module pec_tcdm_rr_arbiter #(
    parameter int unsigned NB_REQ     = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_OUTST  = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NB_REQ-1:0]                req_i,
    output logic [NB_REQ-1:0]                gnt_o,
    input  logic [NB_REQ*ADDR_WIDTH-1:0]     add_i,
    input  logic [NB_REQ-1:0]                wen_i,
    input  logic [NB_REQ*(DATA_WIDTH/8)-1:0] be_i,
    input  logic [NB_REQ*DATA_WIDTH-1:0]     data_i,
    output logic [DATA_WIDTH-1:0]            r_data_o,
    output logic [NB_REQ-1:0]                r_valid_o,
    output logic                             tcdm_req_o,
    input  logic                             tcdm_gnt_i,
    output logic [ADDR_WIDTH-1:0]            tcdm_add_o,
    output logic                             tcdm_wen_o,
    output logic [DATA_WIDTH/8-1:0]          tcdm_be_o,
    output logic [DATA_WIDTH-1:0]            tcdm_data_o,
    input  logic [DATA_WIDTH-1:0]            tcdm_r_data_i,
    input  logic                             tcdm_r_valid_i,
`ifdef PEC_TCDM_ARB_STATS_EN
    input  logic                             stat_clr_i,
    output logic [NB_REQ*16-1:0]             stat_gnt_o,
`endif
    output logic                             err_o
);

    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_W    = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;
    localparam int unsigned PTR_W    = $clog2(MAX_OUTST);

    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] win_q;
    logic             lock_q;
    logic [IDX_W-1:0] rr_winner;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] fifo_q [MAX_OUTST];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   cnt_q;
    logic             full;
    logic             empty;
    logic             handshake;
    logic             pop;
    logic             stray;

    // First requester at or after rr_ptr, wrapping modulo NB_REQ.
    always_comb begin
        int  cand;
        logic found;
        rr_winner = rr_ptr_q;
        found     = 1'b0;
        cand      = 0;
        for (int i = 0; i < int'(NB_REQ); i++) begin
            cand = (int'(rr_ptr_q) + i) % int'(NB_REQ);
            if (!found && req_i[cand]) begin
                found     = 1'b1;
                rr_winner = IDX_W'(cand);
            end
        end
    end

    assign winner     = lock_q ? win_q : rr_winner;
    assign full       = (cnt_q == (PTR_W+1)'(MAX_OUTST));
    assign empty      = (cnt_q == '0);
    assign tcdm_req_o = !rst_i && !full && (lock_q || (|req_i));
    assign handshake  = tcdm_req_o && tcdm_gnt_i;
    assign pop        = tcdm_r_valid_i && !empty;
    assign stray      = tcdm_r_valid_i && empty;
    assign r_data_o   = tcdm_r_data_i;

    always_comb begin
        tcdm_add_o  = '0;
        tcdm_wen_o  = 1'b0;
        tcdm_be_o   = '0;
        tcdm_data_o = '0;
        gnt_o       = '0;
        r_valid_o   = '0;
        if (tcdm_req_o) begin
            tcdm_add_o  = add_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
            tcdm_wen_o  = wen_i[winner];
            tcdm_be_o   = be_i[int'(winner)*BE_WIDTH +: BE_WIDTH];
            tcdm_data_o = data_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
        end
        if (handshake) begin
            gnt_o[winner] = 1'b1;
        end
        if (pop) begin
            r_valid_o[fifo_q[rd_ptr_q]] = 1'b1;
        end
    end

    // A stalled request locks its winner so the presented transaction cannot change.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            win_q    <= '0;
            lock_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_o    <= 1'b0;
        end else begin
            if (handshake) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                rr_ptr_q <= (winner == IDX_W'(NB_REQ - 1)) ? '0 : winner + IDX_W'(1);
                lock_q   <= 1'b0;
            end else if (tcdm_req_o) begin
                lock_q <= 1'b1;
                win_q  <= winner;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (handshake && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!handshake && pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (stray) begin
                err_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (handshake) begin
            fifo_q[wr_ptr_q] <= winner;
        end
    end

`ifdef PEC_TCDM_ARB_STATS_EN
    // Saturating per-requester grant counters; clear wins over a coincident grant.
    for (genvar g = 0; g < int'(NB_REQ); g++) begin : gen_stat
        logic [15:0] stat_q;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                stat_q <= '0;
            end else if (stat_clr_i) begin
                stat_q <= '0;
            end else if (handshake && (winner == IDX_W'(g)) && (stat_q != 16'hFFFF)) begin
                stat_q <= stat_q + 16'd1;
            end
        end
        assign stat_gnt_o[g*16 +: 16] = stat_q;
    end
`endif

endmodule

// File: tb/tb_pec_tcdm_rr_arbiter.sv
// Self-checking bench for pec_tcdm_rr_arbiter: directed scenarios plus random traffic
// compared against a queue-based reference model of the arbitration rules.
module tb_pec_tcdm_rr_arbiter;

    localparam int NB = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NB-1:0]    req;
    logic [NB-1:0]    gnt;
    logic [NB*AW-1:0] add;
    logic [NB-1:0]    wen;
    logic [NB*BW-1:0] be;
    logic [NB*DW-1:0] wdata;
    logic [DW-1:0]    r_data;
    logic [NB-1:0]    r_valid;
    logic             tcdm_req;
    logic             tcdm_gnt;
    logic [AW-1:0]    tcdm_add;
    logic             tcdm_wen;
    logic [BW-1:0]    tcdm_be;
    logic [DW-1:0]    tcdm_data;
    logic [DW-1:0]    tcdm_r_data;
    logic             tcdm_r_valid;
    logic             err;
`ifdef PEC_TCDM_ARB_STATS_EN
    logic             stat_clr;
    logic [NB*16-1:0] stat_gnt;
`endif

    always #5 clk = ~clk;

    pec_tcdm_rr_arbiter #(
        .NB_REQ(NB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .add_i(add), .wen_i(wen),
        .be_i(be), .data_i(wdata), .r_data_o(r_data), .r_valid_o(r_valid),
        .tcdm_req_o(tcdm_req), .tcdm_gnt_i(tcdm_gnt), .tcdm_add_o(tcdm_add),
        .tcdm_wen_o(tcdm_wen), .tcdm_be_o(tcdm_be), .tcdm_data_o(tcdm_data),
        .tcdm_r_data_i(tcdm_r_data), .tcdm_r_valid_i(tcdm_r_valid),
`ifdef PEC_TCDM_ARB_STATS_EN
        .stat_clr_i(stat_clr), .stat_gnt_o(stat_gnt),
`endif
        .err_o(err)
    );

    // Per-requester transaction being offered.
    logic          req_v  [NB];
    logic [AW-1:0] add_v  [NB];
    logic [DW-1:0] data_v [NB];
    logic [BW-1:0] be_v   [NB];
    logic          wen_v  [NB];

    // Reference model state.
    int m_rr;
    bit m_lock;
    int m_lwin;
    int m_q[$];
    bit m_err;
    int m_stat[NB];

    int total = 0;
    int bad   = 0;

    logic [NB-1:0] last_gnt;
    logic [NB-1:0] last_rvalid;
    logic          last_req;
    logic          last_err;
    logic [DW-1:0] last_rdata;
    logic [AW-1:0] last_add;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic setReq(input int i);
        req_v[i]  = 1'b1;
        add_v[i]  = $urandom;
        data_v[i] = $urandom;
        be_v[i]   = BW'($urandom);
        wen_v[i]  = 1'($urandom);
    endtask

    task automatic modelReset();
        m_rr   = 0;
        m_lock = 0;
        m_lwin = 0;
        m_q.delete();
        m_err  = 0;
        for (int i = 0; i < NB; i++) m_stat[i] = 0;
    endtask

    // One clock cycle: drive on the falling edge, check 1 time unit later, advance model.
    task automatic applyStimulus(input bit r, input bit g, input bit rv, input logic [DW-1:0] rd, input bit clr);
        bit            any;
        bit            exp_req;
        bit            hs;
        bit            popped;
        int            win;
        logic [NB-1:0] exp_gnt;
        logic [NB-1:0] exp_rv;
        @(negedge clk);
        rst          = r;
        tcdm_gnt     = g;
        tcdm_r_valid = rv;
        tcdm_r_data  = rd;
`ifdef PEC_TCDM_ARB_STATS_EN
        stat_clr     = clr;
`endif
        for (int i = 0; i < NB; i++) begin
            req[i]             = req_v[i];
            add[i*AW +: AW]    = add_v[i];
            wdata[i*DW +: DW]  = data_v[i];
            be[i*BW +: BW]     = be_v[i];
            wen[i]             = wen_v[i];
        end
        #1;
        if (r) modelReset();
        any = m_lock;
        for (int i = 0; i < NB; i++) any = any | req_v[i];
        exp_req = !r && (m_q.size() < MO) && any;
        win = m_lwin;
        if (!m_lock) begin
            win = -1;
            for (int k = 0; k < NB; k++)
                if (win < 0 && req_v[(m_rr + k) % NB]) win = (m_rr + k) % NB;
            if (win < 0) win = 0;
        end
        hs      = exp_req && g;
        popped  = !r && rv && (m_q.size() > 0);
        exp_gnt = '0;
        if (hs) exp_gnt[win] = 1'b1;
        exp_rv = '0;
        if (popped) exp_rv[m_q[0]] = 1'b1;

        checkOutput("tcdm_req", 64'(tcdm_req), 64'(exp_req));
        checkOutput("gnt", 64'(gnt), 64'(exp_gnt));
        checkOutput("tcdm_add", 64'(tcdm_add), exp_req ? 64'(add_v[win]) : 64'd0);
        checkOutput("tcdm_wen", 64'(tcdm_wen), exp_req ? 64'(wen_v[win]) : 64'd0);
        checkOutput("tcdm_be", 64'(tcdm_be), exp_req ? 64'(be_v[win]) : 64'd0);
        checkOutput("tcdm_data", 64'(tcdm_data), exp_req ? 64'(data_v[win]) : 64'd0);
        checkOutput("r_valid", 64'(r_valid), 64'(exp_rv));
        checkOutput("r_data", 64'(r_data), 64'(rd));
        checkOutput("err", 64'(err), 64'(m_err));
`ifdef PEC_TCDM_ARB_STATS_EN
        for (int i = 0; i < NB; i++)
            checkOutput("stat_gnt", 64'(stat_gnt[i*16 +: 16]), 64'(m_stat[i]));
`endif
        last_gnt    = gnt;
        last_rvalid = r_valid;
        last_req    = tcdm_req;
        last_err    = err;
        last_rdata  = r_data;
        last_add    = tcdm_add;

        if (!r) begin
            if (popped) void'(m_q.pop_front());
            else if (rv) m_err = 1;
            if (hs) begin
                m_q.push_back(win);
                m_rr   = (win + 1) % NB;
                m_lock = 0;
            end else if (exp_req) begin
                m_lock = 1;
                m_lwin = win;
            end
            for (int i = 0; i < NB; i++) begin
                if (clr) m_stat[i] = 0;
                else if (hs && win == i && m_stat[i] < 65535) m_stat[i]++;
            end
        end
        if (hs) req_v[win] = 1'b0;
    endtask

    task automatic clearReqs();
        for (int i = 0; i < NB; i++) req_v[i] = 1'b0;
    endtask

    task automatic doReset();
        clearReqs();
        applyStimulus(1, 0, 0, '0, 0);
    endtask

    initial begin
        logic [DW-1:0] resp [4];
        logic [NB-1:0] exp_seq [4];
        rst = 1'b1; tcdm_gnt = 1'b0; tcdm_r_valid = 1'b0; tcdm_r_data = '0;
        req = '0; add = '0; wen = '0; be = '0; wdata = '0;
`ifdef PEC_TCDM_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        for (int i = 0; i < NB; i++) begin
            req_v[i] = 0; add_v[i] = '0; data_v[i] = '0; be_v[i] = '0; wen_v[i] = 0;
        end
        modelReset();
        doReset();
        checkOutput("reset_req", 64'(last_req), 64'd0);
        checkOutput("reset_gnt", 64'(last_gnt), 64'd0);
        checkOutput("reset_err", 64'(last_err), 64'd0);

        // Rotation with both requesting and constant grant.
        doReset();
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
        for (int c = 0; c < 4; c++) begin
            setReq(0); setReq(1);
            applyStimulus(0, 1, 0, '0, 0);
            checkOutput("rot_gnt", 64'(last_gnt), 64'(exp_seq[c]));
        end

        // Winner lock: requester 1 appears while requester 0 is stalled and has priority via rr.
        doReset();
        setReq(0); applyStimulus(0, 1, 0, '0, 0);
        setReq(0); applyStimulus(0, 0, 0, '0, 0);
        checkOutput("lock_add0", 64'(last_add), 64'(add_v[0]));
        setReq(1); applyStimulus(0, 0, 0, '0, 0);
        checkOutput("lock_add1", 64'(last_add), 64'(add_v[0]));
        applyStimulus(0, 1, 0, '0, 0);
        checkOutput("lock_gnt0", 64'(last_gnt), 64'(2'b01));
        applyStimulus(0, 1, 0, '0, 0);
        checkOutput("lock_gnt1", 64'(last_gnt), 64'(2'b10));

        // Full stall and resume after a pop.
        doReset();
        for (int c = 0; c < MO; c++) begin
            setReq(0); applyStimulus(0, 1, 0, '0, 0);
            checkOutput("fill_gnt", 64'(last_gnt), 64'(2'b01));
        end
        setReq(0); applyStimulus(0, 1, 0, '0, 0);
        checkOutput("full_req", 64'(last_req), 64'd0);
        applyStimulus(0, 1, 1, 32'h1234_5678, 0);
        checkOutput("full_pop_gnt", 64'(last_gnt), 64'd0);
        checkOutput("full_pop_rv", 64'(last_rvalid), 64'(2'b01));
        applyStimulus(0, 1, 0, '0, 0);
        checkOutput("resume_gnt", 64'(last_gnt), 64'(2'b01));

        // Response routing in grant order 0,1,1,0.
        doReset();
        setReq(0); applyStimulus(0, 1, 0, '0, 0);
        setReq(1); applyStimulus(0, 1, 0, '0, 0);
        setReq(1); applyStimulus(0, 1, 0, '0, 0);
        setReq(0); applyStimulus(0, 1, 0, '0, 0);
        resp[0] = 32'hAAAA_0001; resp[1] = 32'hBBBB_0002;
        resp[2] = 32'hCCCC_0003; resp[3] = 32'hDDDD_0004;
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b10; exp_seq[3] = 2'b01;
        for (int c = 0; c < 4; c++) begin
            applyStimulus(0, 0, 1, resp[c], 0);
            checkOutput("route_rv", 64'(last_rvalid), 64'(exp_seq[c]));
            checkOutput("route_data", 64'(last_rdata), 64'(resp[c]));
        end

`ifdef PEC_TCDM_ARB_STATS_EN
        // Five grants to requester 1, then clear coinciding with a grant.
        doReset();
        for (int c = 0; c < 5; c++) begin
            setReq(1); applyStimulus(0, 1, c > 0, '0, 0);
        end
        setReq(1); applyStimulus(0, 1, 1, '0, 1);
        checkOutput("stat_five", 64'(stat_gnt[31:16]), 64'd5);
        applyStimulus(0, 0, 1, '0, 0);
        checkOutput("stat_clr", 64'(stat_gnt[31:16]), 64'd0);
`endif

        // Random traffic.
        doReset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NB; i++)
                if (!req_v[i] && ($urandom % 2 == 0)) setReq(i);
            if ($urandom % 150 == 0) begin
                applyStimulus(1, 1, 0, '0, 0);
            end else begin
                applyStimulus(0, ($urandom % 4) != 0, (m_q.size() > 0) && ($urandom % 2 == 0),
                              $urandom, ($urandom % 25) == 0);
            end
        end

        // Reset with outstanding transactions, then stray responses.
        doReset();
        setReq(0); applyStimulus(0, 1, 0, '0, 0);
        setReq(1); applyStimulus(0, 1, 0, '0, 0);
        doReset();
        applyStimulus(0, 0, 1, 32'hDEAD_0001, 0);
        checkOutput("stray_rv0", 64'(last_rvalid), 64'd0);
        applyStimulus(0, 0, 1, 32'hDEAD_0002, 0);
        checkOutput("stray_rv1", 64'(last_rvalid), 64'd0);
        checkOutput("stray_err", 64'(last_err), 64'd1);
        applyStimulus(0, 0, 0, '0, 0);
        checkOutput("stray_sticky", 64'(last_err), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pec_tcdm_rr_arbiter.md
Name: pec_tcdm_rr_arbiter

Overview:
Round-robin arbiter that shares one TCDM master port among NB_REQ requesters, such as the PEC streamer source/sink channels and a future weight-load channel. It forwards the request of the winning requester, tracks outstanding transactions in an ID FIFO, and routes in-order responses back to the issuing requester. It sits between the streamer channels and the cluster TCDM interconnect.

Parameters:
NB_REQ, 2, number of requesters (>=2)
ADDR_WIDTH, 32, TCDM address width
DATA_WIDTH, 32, TCDM data width
MAX_OUTST, 4, max in-flight transactions (power of 2, >=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req_i  in  NB_REQ  per-requester request
gnt_o  out  NB_REQ  per-requester grant (one-hot or zero)
add_i  in  NB_REQ*ADDR_WIDTH  request addresses
wen_i  in  NB_REQ  1 = read, 0 = write
be_i  in  NB_REQ*(DATA_WIDTH/8)  byte enables
data_i  in  NB_REQ*DATA_WIDTH  write data
r_data_o  out  DATA_WIDTH  response data, broadcast to all requesters
r_valid_o  out  NB_REQ  per-requester response valid (one-hot or zero)
tcdm_req_o  out  1  master request
tcdm_gnt_i  in  1  master grant
tcdm_add_o  out  ADDR_WIDTH  master address
tcdm_wen_o  out  1  master write enable (1 = read)
tcdm_be_o  out  DATA_WIDTH/8  master byte enables
tcdm_data_o  out  DATA_WIDTH  master write data
tcdm_r_data_i  in  DATA_WIDTH  master response data
tcdm_r_valid_i  in  1  master response valid (asserted for reads and writes)
err_o  out  1  sticky: response arrived with no transaction outstanding

Behaviour:
- Reset (asynchronous, rst_i=1): rr_ptr=0, lock=0, FIFO empty, cnt=0, err_o=0. As a result, gnt_o=0, r_valid_o=0, and tcdm_req_o=0 while rst_i is high.
- full = (cnt==MAX_OUTST). tcdm_req_o = !full && (lock || |req_i).
- Winner selection when lock=0: scan from rr_ptr upward, modulo NB_REQ; the first index with req_i set wins. When lock=1, the winner is the stored win_q.
- Stability rule: if tcdm_req_o=1 and tcdm_gnt_i=0, set lock=1 and win_q=winner. While lock=1, the winner does not change even if a higher-priority requester asserts. Requesters must hold req, add, wen, be and data until they are granted.
- Address/data mux: tcdm_add_o, tcdm_wen_o, tcdm_be_o and tcdm_data_o are taken combinationally from the winner. When tcdm_req_o=0 these outputs are 0.
- Handshake: gnt_o[winner] = tcdm_req_o && tcdm_gnt_i. This is zero latency, so the grant appears in the same cycle as tcdm_gnt_i.
- On a handshake:
  - push the winner index into the FIFO
  - rr_ptr <= (winner+1) mod NB_REQ
  - lock <= 0
- Response path: on tcdm_r_valid_i with the FIFO non-empty:
  - r_valid_o[head]=1, same cycle, combinational
  - r_data_o = tcdm_r_data_i
  - pop the FIFO
- Stray response: tcdm_r_valid_i with the FIFO empty sets err_o=1 (sticky until reset). No r_valid_o is raised and the FIFO is unchanged.
- Simultaneous push and pop: cnt stays the same and FIFO order is preserved. When full, no grant is issued in that cycle even if a pop occurs; the grant resumes the next cycle.
- Wrap-around: FIFO pointers are log2(MAX_OUTST) bits and wrap naturally. cnt is log2(MAX_OUTST)+1 bits.
- Reset during operation discards in-flight IDs. A response that arrives after reset triggers err_o.
- Minimum response latency is 1 cycle after the grant. Sustained throughput is one transaction per cycle.

Optional Feature:
Macro PEC_TCDM_ARB_STATS_EN.
- Defined: adds output stat_gnt_o of width NB_REQ*16. It holds a per-requester 16-bit grant counter that increments on each handshake, saturates at 0xFFFF, and clears on reset. It also adds input stat_clr_i, a synchronous clear of all counters; if a clear and a handshake occur in the same cycle, the counter becomes 0.
- Undefined: the ports and counters are absent. Arbitration behaviour is identical in both cases.

Test Plan:
- Rotation: req_i=2'b11 held, tcdm_gnt_i=1 constant. Grants alternate 01,10,01,10; rr_ptr returns to 0; four pushes are made.
- Winner lock: req_i=01, tcdm_gnt_i=0 for 3 cycles, req_i[1] raised in cycle 2, then gnt=1. The grant goes to requester 0, tcdm_add_o equals add_i[0] throughout, and requester 1 is granted next.
- Full stall: MAX_OUTST=4, 4 grants with no responses. tcdm_req_o=0 in the fifth cycle. One r_valid arrives in the same cycle as a pending request; the grant is issued the following cycle.
- Response routing: grants issued in the order 0,1,1,0 with responses of data A,B,C,D. r_valid_o sequence is 01,10,10,01, and r_data_o matches each.
- Stray and reset: assert rst_i with 2 outstanding, release it, then 2 r_valid pulses arrive. err_o=1 after the first pulse and no r_valid_o is raised.
- Stats (PEC_TCDM_ARB_STATS_EN): 5 grants to requester 1. stat_gnt_o[1]=5. Pulsing stat_clr_i together with a grant gives 0.
